// File: rtl/uart_seq_trig_if.sv
// uart_seq_trig_if: configuration and result bundle of the UART sequence trigger.
//   master : trigger-path controller; drives enable, baud, sequence configuration
//            and trig_clr; observes the trigger, received word and matcher state.
//   slave  : uart_seq_trig itself.
// Signals:
//   en, baud_cnt, seq_len, match_vec, mask_vec, trig_clr  (master -> slave)
//   UARTtrig, rx_data, rx_rdy, seq_idx                     (slave -> master)
interface uart_seq_trig_if #(
  parameter int DATA_W  = 8,
  parameter int SEQ_LEN = 4,
  parameter int BAUD_W  = 16
);
  localparam int IDX_W = $clog2(SEQ_LEN) + 1;

  logic                        en;
  logic [BAUD_W-1:0]           baud_cnt;
  logic [IDX_W-1:0]            seq_len;
  logic [SEQ_LEN*DATA_W-1:0]   match_vec;
  logic [SEQ_LEN*DATA_W-1:0]   mask_vec;
  logic                        trig_clr;
  logic                        UARTtrig;
  logic [DATA_W-1:0]           rx_data;
  logic                        rx_rdy;
  logic [IDX_W-1:0]            seq_idx;

  modport master (
    output en, baud_cnt, seq_len, match_vec, mask_vec, trig_clr,
    input  UARTtrig, rx_data, rx_rdy, seq_idx
  );

  modport slave (
    input  en, baud_cnt, seq_len, match_vec, mask_vec, trig_clr,
    output UARTtrig, rx_data, rx_rdy, seq_idx
  );
endinterface

// File: rtl/uart_seq_trig.sv
// uart_seq_trig: UART receiver (8N1-style, DATA_W data bits, LSB first, no
// parity) followed by a sequence matcher over up to SEQ_LEN consecutive words,
// each with its own match value and don't-care mask. A complete sequence sets
// the sticky UARTtrig, which feeds the protocol-trigger AND term.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   RX     raw capture line, asynchronous to clk
//   bus    uart_seq_trig_if.slave (configuration in, trigger/data/status out)
module uart_seq_trig #(
  parameter int DATA_W  = 8,
  parameter int SEQ_LEN = 4,
  parameter int BAUD_W  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           RX,
  uart_seq_trig_if.slave bus
);

  localparam int IDX_W = $clog2(SEQ_LEN) + 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t            state_r;
  logic              rx_meta_r;
  logic              rx_sync_r;
  logic              rx_prev_r;
  logic [BAUD_W-1:0] cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              rx_rdy_r;
  logic [IDX_W-1:0]  seq_idx_r;
  logic              trig_r;

  logic [BAUD_W-1:0] eb_s;
  logic [BAUD_W-1:0] half_s;
  logic              cnt_exp_s;
  logic [IDX_W-1:0]  len_s;
  logic [IDX_W-1:0]  idx_plus_s;
  logic              match0_s;
  logic              match_cur_s;
  logic              set_trig_s;
  logic [IDX_W-1:0]  idx_nxt_s;

  // Masked compare: bits with mask=1 are ignored.
  function automatic logic word_match(input logic [DATA_W-1:0] w,
                                      input logic [DATA_W-1:0] m,
                                      input logic [DATA_W-1:0] k);
    return ((w & ~k) == (m & ~k));
  endfunction

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= RX;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Effective bit period, clamped length and next matcher state for the word in shift_r.
  always_comb begin
    eb_s        = bus.baud_cnt;
    len_s       = bus.seq_len;
    match_cur_s = 1'b0;
    set_trig_s  = 1'b0;
    idx_nxt_s   = '0;
    if (bus.baud_cnt < BAUD_W'(2)) begin
      eb_s = BAUD_W'(2);
    end else begin
      eb_s = bus.baud_cnt;
    end
    half_s    = eb_s >> 1;
    // "<= 1" rather than "== 1" so a counter left at 0 by a live baud change still expires.
    cnt_exp_s = (cnt_r <= BAUD_W'(1));
    if (bus.seq_len == IDX_W'(0)) begin
      len_s = IDX_W'(1);
    end else if (bus.seq_len > IDX_W'(SEQ_LEN)) begin
      len_s = IDX_W'(SEQ_LEN);
    end else begin
      len_s = bus.seq_len;
    end
    match0_s = word_match(shift_r, bus.match_vec[0 +: DATA_W], bus.mask_vec[0 +: DATA_W]);
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (seq_idx_r == IDX_W'(k)) begin
        match_cur_s = word_match(shift_r, bus.match_vec[k*DATA_W +: DATA_W],
                                 bus.mask_vec[k*DATA_W +: DATA_W]);
      end else begin
        match_cur_s = match_cur_s;
      end
    end
    idx_plus_s = seq_idx_r + IDX_W'(1);
    if (match_cur_s) begin
      // ">=" keeps the matcher sane if seq_len shrinks below the current index.
      if (idx_plus_s >= len_s) begin
        set_trig_s = 1'b1;
        idx_nxt_s  = '0;
      end else begin
        idx_nxt_s  = idx_plus_s;
      end
    end else if (match0_s) begin
      if (len_s == IDX_W'(1)) begin
        set_trig_s = 1'b1;
        idx_nxt_s  = '0;
      end else begin
        idx_nxt_s  = IDX_W'(1);
      end
    end else begin
      idx_nxt_s = '0;
    end
  end

  // Receiver FSM, matcher state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      bit_cnt_r <= '0;
      shift_r   <= '0;
      rx_data_r <= '0;
      rx_rdy_r  <= 1'b0;
      seq_idx_r <= '0;
      trig_r    <= 1'b0;
    end else begin
      rx_rdy_r <= 1'b0;
      if (bus.trig_clr) begin
        trig_r <= 1'b0;
      end
      if (!bus.en) begin
        state_r   <= IDLE;
        seq_idx_r <= '0;
        cnt_r     <= '0;
        bit_cnt_r <= '0;
      end else begin
        case (state_r)
          IDLE: begin
            if (rx_prev_r && !rx_sync_r) begin
              cnt_r   <= half_s;
              state_r <= START;
            end
          end
          START: begin
            if (cnt_exp_s) begin
              if (!rx_sync_r) begin
                cnt_r     <= eb_s;
                bit_cnt_r <= '0;
                state_r   <= DATA;
              end else begin
                state_r   <= IDLE;
              end
            end else begin
              cnt_r <= cnt_r - BAUD_W'(1);
            end
          end
          DATA: begin
            if (cnt_exp_s) begin
              shift_r   <= {rx_sync_r, shift_r[DATA_W-1:1]};
              cnt_r     <= eb_s;
              bit_cnt_r <= bit_cnt_r + BIT_W'(1);
              if (bit_cnt_r == BIT_W'(DATA_W - 1)) begin
                state_r <= STOP;
              end
            end else begin
              cnt_r <= cnt_r - BAUD_W'(1);
            end
          end
          STOP: begin
            if (cnt_exp_s) begin
              if (rx_sync_r) begin
                rx_data_r <= shift_r;
                rx_rdy_r  <= 1'b1;
                seq_idx_r <= idx_nxt_s;
                // Placed after the trig_clr clear so a completing match wins.
                if (set_trig_s) begin
                  trig_r <= 1'b1;
                end
                state_r <= IDLE;
              end else begin
                seq_idx_r <= '0;
                state_r   <= BREAK;
              end
            end else begin
              cnt_r <= cnt_r - BAUD_W'(1);
            end
          end
          BREAK: begin
            if (rx_sync_r) begin
              state_r <= IDLE;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.UARTtrig = trig_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_rdy   = rx_rdy_r;
  assign bus.seq_idx  = seq_idx_r;

endmodule

// File: tb/tb_uart_seq_trig.sv
// tb_uart_seq_trig: directed, table-driven bench for uart_seq_trig
// (DATA_W=8, SEQ_LEN=4, baud_cnt=16) with hand-written control corner sequences.
module tb_uart_seq_trig;

  localparam int BAUD = 16;

  logic clk;
  logic rst_n;
  logic RX;

  uart_seq_trig_if #(.DATA_W(8), .SEQ_LEN(4), .BAUD_W(16)) u_if();

  uart_seq_trig #(.DATA_W(8), .SEQ_LEN(4), .BAUD_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (RX),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;
  int rdy_cnt;

  // Count every cycle rx_rdy is high; a pulse longer than one cycle shows up as an extra count.
  always @(negedge clk) begin
    if (u_if.rx_rdy === 1'b1) rdy_cnt = rdy_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_bit(input logic b, input logic clr_watch);
    RX = b;
    repeat (BAUD) begin
      @(posedge clk); #1;
      if (clr_watch && u_if.rx_rdy === 1'b1) u_if.trig_clr = 1'b0;
    end
  endtask

  // Full frame plus two idle bit times; with clr_watch, trig_clr is held high
  // through the stop bit until the cycle the frame completes.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic clr_watch);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
    if (clr_watch) u_if.trig_clr = 1'b1;
    send_bit(stop, clr_watch);
    u_if.trig_clr = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
  endtask

  task automatic pulse_clr();
    @(negedge clk); u_if.trig_clr = 1'b1;
    @(negedge clk); u_if.trig_clr = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  len;
    logic [31:0] match;
    logic [31:0] mask;
    logic        clr;
    logic [7:0]  data;
    logic        stop;
    logic        exp_rdy;
    logic [2:0]  exp_idx;
    logic        exp_trig;
  } vec_t;

  vec_t vecs[19];

  initial begin
    int          r0;
    logic [7:0]  exp_data;
    logic [7:0]  d;

    n_pass = 0; n_total = 0; rdy_cnt = 0;
    exp_data = 8'h00;

    //            len   match         mask          clr   data   stop  rdy   idx   trig
    // basic match
    vecs[0]  = '{3'd3, 32'h000FAA55, 32'h00000000, 1'b0, 8'h55, 1'b1, 1'b1, 3'd1, 1'b0};
    vecs[1]  = '{3'd3, 32'h000FAA55, 32'h00000000, 1'b0, 8'hAA, 1'b1, 1'b1, 3'd2, 1'b0};
    vecs[2]  = '{3'd3, 32'h000FAA55, 32'h00000000, 1'b0, 8'h0F, 1'b1, 1'b1, 3'd0, 1'b1};
    // mismatch and restart
    vecs[3]  = '{3'd3, 32'h000FAA55, 32'h00000000, 1'b1, 8'h55, 1'b1, 1'b1, 3'd1, 1'b0};
    vecs[4]  = '{3'd3, 32'h000FAA55, 32'h00000000, 1'b0, 8'h55, 1'b1, 1'b1, 3'd1, 1'b0};
    vecs[5]  = '{3'd3, 32'h000FAA55, 32'h00000000, 1'b0, 8'hAA, 1'b1, 1'b1, 3'd2, 1'b0};
    vecs[6]  = '{3'd3, 32'h000FAA55, 32'h00000000, 1'b0, 8'h0F, 1'b1, 1'b1, 3'd0, 1'b1};
    vecs[7]  = '{3'd3, 32'h000FAA55, 32'h00000000, 1'b1, 8'h55, 1'b1, 1'b1, 3'd1, 1'b0};
    vecs[8]  = '{3'd3, 32'h000FAA55, 32'h00000000, 1'b0, 8'h12, 1'b1, 1'b1, 3'd0, 1'b0};
    // mask
    vecs[9]  = '{3'd1, 32'h000000A0, 32'h0000000F, 1'b1, 8'hA7, 1'b1, 1'b1, 3'd0, 1'b1};
    vecs[10] = '{3'd1, 32'h000000A0, 32'h0000000F, 1'b1, 8'hB0, 1'b1, 1'b1, 3'd0, 1'b0};
    // framing error
    vecs[11] = '{3'd2, 32'h00002211, 32'h00000000, 1'b0, 8'h11, 1'b1, 1'b1, 3'd1, 1'b0};
    vecs[12] = '{3'd2, 32'h00002211, 32'h00000000, 1'b0, 8'h22, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[13] = '{3'd2, 32'h00002211, 32'h00000000, 1'b0, 8'h22, 1'b1, 1'b1, 3'd0, 1'b0};
    // seq_len=0 clamps to 1
    vecs[14] = '{3'd0, 32'h0000003C, 32'h00000000, 1'b0, 8'h3C, 1'b1, 1'b1, 3'd0, 1'b1};
    // seq_len=7 clamps to 4
    vecs[15] = '{3'd7, 32'h04030201, 32'h00000000, 1'b1, 8'h01, 1'b1, 1'b1, 3'd1, 1'b0};
    vecs[16] = '{3'd7, 32'h04030201, 32'h00000000, 1'b0, 8'h02, 1'b1, 1'b1, 3'd2, 1'b0};
    vecs[17] = '{3'd7, 32'h04030201, 32'h00000000, 1'b0, 8'h03, 1'b1, 1'b1, 3'd3, 1'b0};
    vecs[18] = '{3'd7, 32'h04030201, 32'h00000000, 1'b0, 8'h04, 1'b1, 1'b1, 3'd0, 1'b1};

    // reset
    rst_n = 1'b0; RX = 1'b1;
    u_if.en = 1'b1; u_if.baud_cnt = 16'd16; u_if.seq_len = 3'd3;
    u_if.match_vec = 32'h000FAA55; u_if.mask_vec = 32'h0; u_if.trig_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_trig", {31'd0, u_if.UARTtrig}, 32'd0);
    chk("reset_rdy",  {31'd0, u_if.rx_rdy},   32'd0);
    chk("reset_data", {24'd0, u_if.rx_data},  32'd0);
    chk("reset_idx",  {29'd0, u_if.seq_idx},  32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 3-cycle glitch must not produce a frame
    r0 = rdy_cnt;
    RX = 1'b0; repeat (3) @(negedge clk);
    RX = 1'b1; repeat (40) @(negedge clk);
    chk("glitch_rdy", rdy_cnt - r0, 32'd0);

    // table
    for (int v = 0; v < 19; v++) begin
      u_if.seq_len   = vecs[v].len;
      u_if.match_vec = vecs[v].match;
      u_if.mask_vec  = vecs[v].mask;
      if (vecs[v].clr) pulse_clr();
      r0 = rdy_cnt;
      send_frame(vecs[v].data, vecs[v].stop, 1'b0);
      if (vecs[v].exp_rdy) exp_data = vecs[v].data;
      chk($sformatf("v%0d_rdy", v),  rdy_cnt - r0, {31'd0, vecs[v].exp_rdy});
      chk($sformatf("v%0d_idx", v),  {29'd0, u_if.seq_idx},  {29'd0, vecs[v].exp_idx});
      chk($sformatf("v%0d_trig", v), {31'd0, u_if.UARTtrig}, {31'd0, vecs[v].exp_trig});
      chk($sformatf("v%0d_data", v), {24'd0, u_if.rx_data},  {24'd0, exp_data});
    end

    // trig_clr in the completing cycle: set wins
    u_if.seq_len = 3'd1; u_if.match_vec = 32'h0000005A; u_if.mask_vec = 32'h0;
    pulse_clr();
    chk("clr_pulse_trig", {31'd0, u_if.UARTtrig}, 32'd0);
    r0 = rdy_cnt;
    send_frame(8'h5A, 1'b1, 1'b1);
    chk("setwin_rdy",  rdy_cnt - r0, 32'd1);
    chk("setwin_trig", {31'd0, u_if.UARTtrig}, 32'd1);

    // en dropped mid-frame: frame discarded, seq_idx cleared, trig/data held
    u_if.seq_len = 3'd2; u_if.match_vec = 32'h00002211;
    send_frame(8'h11, 1'b1, 1'b0);
    chk("en_pre_idx", {29'd0, u_if.seq_idx}, 32'd1);
    r0 = rdy_cnt;
    d = 8'h22;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) u_if.en = 1'b0;
      send_bit(d[i], 1'b0);
    end
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("en_idx",  {29'd0, u_if.seq_idx},  32'd0);
    chk("en_trig", {31'd0, u_if.UARTtrig}, 32'd1);
    chk("en_data", {24'd0, u_if.rx_data},  32'h11);
    u_if.en = 1'b1;
    send_bit(1'b1, 1'b0);
    chk("en_rdy", rdy_cnt - r0, 32'd0);
    r0 = rdy_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    chk("en_resume_rdy", rdy_cnt - r0, 32'd1);
    chk("en_resume_idx", {29'd0, u_if.seq_idx}, 32'd1);

    // async reset mid-frame
    d = 8'h22;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i], 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_trig", {31'd0, u_if.UARTtrig}, 32'd0);
    chk("arst_idx",  {29'd0, u_if.seq_idx},  32'd0);
    chk("arst_data", {24'd0, u_if.rx_data},  32'd0);
    chk("arst_rdy",  {31'd0, u_if.rx_rdy},   32'd0);
    RX = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    r0 = rdy_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    chk("post_rst_rdy", rdy_cnt - r0, 32'd1);
    chk("post_rst_idx", {29'd0, u_if.seq_idx}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
